// File: rtl/trig_pkg.sv
// Shared widths, quadrant type and the elaboration-time quarter-wave table builder
// for the sine/cosine lookup pipeline.
package trig_pkg;

  localparam int unsigned DATA_W  = 17;
  localparam int unsigned FRAC_W  = 10;
  localparam int unsigned STEPS_Q = 6;

  typedef logic [1:0] quad_t;

  // round(sin(k*90deg/steps) * 2^frac), k in 0..steps; Taylor series so no math library is needed
  function automatic int sin_q(int k, int steps = int'(STEPS_Q), int frac = int'(FRAC_W));
    real x;
    real term;
    real acc;
    x    = 3.14159265358979323846 * real'(k) / (2.0 * real'(steps));
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return $rtoi(acc * (2.0 ** frac) + 0.5);
  endfunction

endpackage

// File: rtl/trig_quarter_rom.sv
// Quarter-wave sine magnitude table with two combinational read ports.
module trig_quarter_rom #(
  parameter int unsigned STEPS_Q = 6,
  parameter int unsigned FRAC_W  = 10,
  parameter int unsigned DATA_W  = 17,
  localparam int unsigned ADDR_W = $clog2(STEPS_Q + 1)
) (
  input  logic [ADDR_W-1:0] addr_sin,
  input  logic [ADDR_W-1:0] addr_cos,
  output logic [DATA_W-1:0] mag_sin,
  output logic [DATA_W-1:0] mag_cos
);
  import trig_pkg::*;

  logic [DATA_W-1:0] tbl [STEPS_Q + 1];

  for (genvar k = 0; k <= int'(STEPS_Q); k++) begin : g_tbl
    assign tbl[k] = DATA_W'(sin_q(k, int'(STEPS_Q), int'(FRAC_W)));
  end

  assign mag_sin = tbl[addr_sin];
  assign mag_cos = tbl[addr_cos];

endmodule

// File: rtl/trig_lut_pipe.sv
// Three-stage sin/cos lookup: normalise/range-check, quarter-table lookup, sign apply.
// One global advance enable stalls every stage when the output is held.
module trig_lut_pipe #(
  parameter int unsigned DATA_W  = 17,
  parameter int unsigned FRAC_W  = 10,
  parameter int unsigned STEPS_Q = 6,
  parameter int unsigned ANG_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ANG_W-1:0]  in_angle,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sin_out,
  output logic [DATA_W-1:0] cos_out,
  output logic              out_err
);
  import trig_pkg::*;

  localparam int unsigned R_W  = $clog2(STEPS_Q + 1);
  localparam int          FULL = int'(4 * STEPS_Q);
  localparam int          LIM  = FULL - 1;
  localparam int          STP  = int'(STEPS_Q);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1 combinational: fold negative angles, split into quadrant and offset
  int             ang;
  int             a;
  quad_t          q_c;
  logic [R_W-1:0] r_c;
  logic           err_c;

  always_comb begin
    ang   = int'($signed(in_angle));
    err_c = (ang > LIM) || (ang < -LIM);
    a     = (ang < 0) ? ang + FULL : ang;
    if (a >= 3 * STP)      q_c = 2'd3;
    else if (a >= 2 * STP) q_c = 2'd2;
    else if (a >= STP)     q_c = 2'd1;
    else                   q_c = 2'd0;
    r_c = R_W'(a - int'(q_c) * STP);
    if (err_c) begin
      q_c = 2'd0;
      r_c = '0;
    end
  end

  logic           v1;
  quad_t          q1;
  logic [R_W-1:0] r1;
  logic           err1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      q1   <= 2'd0;
      r1   <= '0;
      err1 <= 1'b0;
    end else if (adv) begin
      v1   <= in_valid;
      q1   <= q_c;
      r1   <= r_c;
      err1 <= err_c;
    end
  end

  // S2: odd quadrants swap which port reads the complementary index
  logic [R_W-1:0]    addr_sin;
  logic [R_W-1:0]    addr_cos;
  logic [DATA_W-1:0] mag_sin;
  logic [DATA_W-1:0] mag_cos;

  assign addr_sin = q1[0] ? R_W'(STEPS_Q) - r1 : r1;
  assign addr_cos = q1[0] ? r1 : R_W'(STEPS_Q) - r1;

  trig_quarter_rom #(
    .STEPS_Q(STEPS_Q),
    .FRAC_W (FRAC_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .addr_sin(addr_sin),
    .addr_cos(addr_cos),
    .mag_sin (mag_sin),
    .mag_cos (mag_cos)
  );

  logic              v2;
  logic              err2;
  logic              neg_sin2;
  logic              neg_cos2;
  logic [DATA_W-1:0] mag_sin2;
  logic [DATA_W-1:0] mag_cos2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2       <= 1'b0;
      err2     <= 1'b0;
      neg_sin2 <= 1'b0;
      neg_cos2 <= 1'b0;
      mag_sin2 <= '0;
      mag_cos2 <= '0;
    end else if (adv) begin
      v2       <= v1;
      err2     <= err1;
      neg_sin2 <= q1[1];
      neg_cos2 <= q1[1] ^ q1[0];
      mag_sin2 <= mag_sin;
      mag_cos2 <= mag_cos;
    end
  end

  // S3: apply quadrant signs; out-of-range entries are forced to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out_err   <= err2;
      sin_out   <= err2 ? '0 : (neg_sin2 ? -mag_sin2 : mag_sin2);
      cos_out   <= err2 ? '0 : (neg_cos2 ? -mag_cos2 : mag_cos2);
    end
  end

endmodule

// File: tb/tb_trig_lut_pipe.sv
// Scoreboard bench for trig_lut_pipe: expectations pushed on input accept,
// popped and compared on output accept.
module tb_trig_lut_pipe;

  localparam int DW = 17;
  localparam int AW = 6;
  localparam int S  = 6;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_angle;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sin_out;
  logic [DW-1:0] cos_out;
  logic          out_err;

  trig_lut_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_angle (in_angle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sin_out  (sin_out),
    .cos_out  (cos_out),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ang;
    int s;
    int c;
    int e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gold(int ang, bit want_cos);
    real rad;
    real v;
    rad = real'(ang) * 90.0 / real'(S) * PI / 180.0;
    v   = want_cos ? $cos(rad) : $sin(rad);
    return $rtoi($floor(v * 1024.0 + 0.5));
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Present one angle and hold it until accepted; expectation is queued at the accepting edge
  task automatic send(input int ang);
    exp_t x;
    bit   done = 1'b0;
    x.ang = ang;
    if (ang > 4 * S - 1 || ang < -(4 * S - 1)) begin
      x.s = 0; x.c = 0; x.e = 1;
    end else begin
      x.s = gold(ang, 1'b0); x.c = gold(ang, 1'b1); x.e = 0;
    end
    in_valid = 1'b1;
    in_angle = AW'(ang);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(x);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk($sformatf("send_timeout[%0d]", ang), 0, 1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("sin[%0d]", mon_e.ang), int'($signed(sin_out)), mon_e.s);
        chk($sformatf("cos[%0d]", mon_e.ang), int'($signed(cos_out)), mon_e.c);
        chk($sformatf("err[%0d]", mon_e.ang), int'(out_err), mon_e.e);
      end
    end
  end

  initial begin
    int            t0;
    int            n;
    logic [DW-1:0] s0;
    logic [DW-1:0] c0;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_angle  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sin", int'(sin_out), 0);
    chk("rst_cos", int'(cos_out), 0);
    chk("rst_err", int'(out_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Directed points, including the 17'h1FEF7 negative sine
    send(2);
    send(-1);
    send(12);
    repeat (4) @(posedge clk);
    #1;

    // Full legal sweep back-to-back: must take exactly one cycle per angle
    t0 = cyc;
    for (int a = -23; a <= 23; a++) send(a);
    chk("stream_cycles", cyc - t0, 47);

    // Range boundaries and out-of-range neighbours
    send(22); send(23); send(24); send(-24); send(-23); send(31); send(-32); send(6); send(-6);
    repeat (5) @(posedge clk);
    #1;

    // Output stall: three accepted, then backpressure must hold everything
    out_ready = 1'b0;
    send(1); send(2); send(3);
    @(negedge clk);
    s0 = sin_out;
    c0 = cos_out;
    chk("stall_valid", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_sin_stable", int'(sin_out), int'(s0));
      chk("stall_cos_stable", int'(cos_out), int'(c0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(4); send(5);
    repeat (5) @(posedge clk);
    #1;

    // Mid-stream reset discards the in-flight entries
    send(5); send(6); send(7);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_sin", int'(sin_out), 0);
    chk("mrst_cos", int'(cos_out), 0);
    chk("mrst_err", int'(out_err), 0);
    @(posedge clk);
    #1;
    send(8);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("latency", n, 3);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
